// File: rtl/ball_bounce_multi_if.sv
// Video-side bundle for ball_bounce_multi: beam position/timing in, colour and bounce pulses out.
interface ball_bounce_multi_if #(
  parameter int COORD_W   = 9,
  parameter int NUM_BALLS = 2
);
  logic                 display_on;
  logic [COORD_W-1:0]   hpos;
  logic [COORD_W-1:0]   vpos;
  logic                 vsync;
  logic [2:0]           rgb;
  logic [NUM_BALLS-1:0] bounce;

  modport master (output display_on, hpos, vpos, vsync, input rgb, bounce);
  modport slave  (input display_on, hpos, vpos, vsync, output rgb, bounce);
endinterface

// File: rtl/ball_bounce_multi.sv
// NUM_BALLS square balls bouncing off the screen edges, rendered as registered 3-bit RGB.
// Optional macro BALL_OVERLAP_EN: balls that touched on screen reverse horizontally on the next frame.
module ball_bounce_multi #(
  parameter int NUM_BALLS = 2,
  parameter int BALL_SIZE = 20,
  parameter int H_MAX     = 256,
  parameter int V_MAX     = 240,
  parameter int COORD_W   = 9,
  parameter int SPEED     = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pause,
  ball_bounce_multi_if.slave  vid
);

  localparam int CW1 = COORD_W + 1;
  localparam logic [COORD_W:0]   X_LIM = CW1'(H_MAX - BALL_SIZE);
  localparam logic [COORD_W:0]   Y_LIM = CW1'(V_MAX - BALL_SIZE);
  localparam logic [COORD_W:0]   STEP  = CW1'(SPEED);
  localparam logic [COORD_W-1:0] SIZE  = COORD_W'(BALL_SIZE);

  logic [COORD_W-1:0]   x     [NUM_BALLS];
  logic [COORD_W-1:0]   y     [NUM_BALLS];
  logic [COORD_W-1:0]   x_nxt [NUM_BALLS];
  logic [COORD_W-1:0]   y_nxt [NUM_BALLS];
  logic [NUM_BALLS-1:0] vx_neg, vy_neg, hb, vb, hit, ovl_flip;
  logic                 vsync_q, rise, tick;
  logic [2:0]           colour, rgb_q;
  logic [NUM_BALLS-1:0] bounce_q;

  // Returns {wall_hit, next_pos}. Landing exactly on either edge counts as a hit.
  function automatic logic [COORD_W:0] advance(input logic [COORD_W-1:0] p,
                                               input logic neg,
                                               input logic [COORD_W:0] lim);
    logic [COORD_W:0] sum;
    sum = {1'b0, p} + STEP;
    if (!neg) begin
      if (sum >= lim) return {1'b1, lim[COORD_W-1:0]};
      return {1'b0, sum[COORD_W-1:0]};
    end
    if ({1'b0, p} <= STEP) return {1'b1, {COORD_W{1'b0}}};
    return {1'b0, p - STEP[COORD_W-1:0]};
  endfunction

  assign rise = vid.vsync & ~vsync_q;
  assign tick = rise & ~pause;

  for (genvar g = 0; g < NUM_BALLS; g++) begin : g_ball
    logic [COORD_W-1:0] dh, dv;
    assign dh     = vid.hpos - x[g];
    assign dv     = vid.vpos - y[g];
    assign hit[g] = (dh < SIZE) && (dv < SIZE);
    assign {hb[g], x_nxt[g]} = advance(x[g], vx_neg[g], X_LIM);
    assign {vb[g], y_nxt[g]} = advance(y[g], vy_neg[g], Y_LIM);
  end

  always_comb begin
    colour = 3'b000;
    for (int i = NUM_BALLS - 1; i >= 0; i--)
      if (hit[i]) colour = 3'(i + 1);
  end

`ifdef BALL_OVERLAP_EN
  logic [NUM_BALLS-1:0] ovl;
  logic                 multi;
  assign multi = (hit & (hit - NUM_BALLS'(1))) != '0;

  // Cleared by every vsync rise, paused or not, so a flag only lives for one frame.
  always_ff @(posedge clk) begin
    if (!reset)                         ovl <= '0;
    else if (rise)                      ovl <= '0;
    else if (vid.display_on && multi)   ovl <= ovl | hit;
  end
  assign ovl_flip = ovl;
`else
  assign ovl_flip = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      vsync_q  <= 1'b0;
      rgb_q    <= 3'b000;
      bounce_q <= '0;
      for (int i = 0; i < NUM_BALLS; i++) begin
        x[i]      <= COORD_W'(16 + 40 * i);
        y[i]      <= COORD_W'(16 + 32 * i);
        vx_neg[i] <= 1'((i % 2) == 1);
        vy_neg[i] <= 1'b0;
      end
    end else begin
      vsync_q  <= vid.vsync;
      rgb_q    <= vid.display_on ? colour : 3'b000;
      bounce_q <= tick ? (hb | vb) : '0;
      if (tick) begin
        for (int i = 0; i < NUM_BALLS; i++) begin
          x[i]      <= x_nxt[i];
          y[i]      <= y_nxt[i];
          vx_neg[i] <= vx_neg[i] ^ (hb[i] | ovl_flip[i]);
          vy_neg[i] <= vy_neg[i] ^ vb[i];
        end
      end
    end
  end

  assign vid.rgb    = rgb_q;
  assign vid.bounce = bounce_q;

endmodule
